mc_alu_ctrl: RTL and testbench
==============================

Name: mc_alu_ctrl

Overview:
- Multi-cycle control unit that drives the 2-bit ALU and reads back its Z and V flags.
- Sequences a MIPS-subset datapath through fetch, decode, execute, memory and writeback.
- Generates Aluc, operand-select, memory and write strobes; traps on overflow and illegal opcodes.
- Sits between the instruction register fields and the datapath/ALU.

Parameters:
- OVF_TRAP, 1, 1 = add/sub/addi overflow (V) traps to EXC and suppresses writeback; 0 = V ignored.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- Op  in  6  IR[31:26]; held stable by the datapath after IrWrite.
- Func  in  6  IR[5:0].
- Z  in  1  ALU zero flag.
- V  in  1  ALU overflow flag.
- Mrdy  in  1  memory ready; completes a read or write in the cycle it is high.
- Aluc  out  2  00 add, 01 sub, 10 and, 11 or.
- AluSrcA  out  1  0 = PC, 1 = regA.
- AluSrcB  out  2  00 regB, 01 const 4, 10 sign-ext imm<<2, 11 imm (sign-ext for add class, zero-ext for andi/ori; datapath extends per ExtZ).
- ExtZ  out  1  zero-extend immediate.
- PcWrite  out  1  PC load strobe.
- PcSrc  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 exception vector.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IrWrite  out  1  IR load strobe.
- RegWrite  out  1  register file write strobe.
- RegDst  out  1  1 = rd, 0 = rt.
- MemToReg  out  1  1 = MDR, 0 = ALUOut.
- Exc  out  1  one-cycle exception pulse.
- Cause  out  1  0 = overflow, 1 = illegal; valid when Exc is high.
- State  out  3  current state, for debug.

Behaviour:
- Reset:
  - State = IF.
  - While Rst is high, all strobes (PcWrite, IrWrite, MemRead, MemWrite, RegWrite, Exc) are forced to 0.
  - Aluc = 00, all selects = 0.
- Supported instructions:
  - R-type (Op = 000000) with Func add 100000, sub 100010, and 100100, or 100101.
  - addi 001000, andi 001100, ori 001101, lw 100011, sw 101011, beq 000100, bne 000101, j 000010.
  - Anything else is illegal.
- IF:
  - MemRead = 1, IorD = 0, AluSrcA = 0, AluSrcB = 01, Aluc = 00, PcSrc = 00.
  - IrWrite = PcWrite = Mrdy.
  - Stay in IF while Mrdy = 0; go to ID on Mrdy = 1.
- ID:
  - AluSrcA = 0, AluSrcB = 10, Aluc = 00 (branch target into ALUOut).
  - j: PcWrite = 1, PcSrc = 10, go to IF.
  - Illegal: go to EXC with Cause = 1.
  - Otherwise go to EXE.
- EXE:
  - R-type: AluSrcA = 1, AluSrcB = 00, Aluc from Func.
  - addi/andi/ori: AluSrcB = 11, Aluc 00/10/11; ExtZ = 1 for andi/ori.
  - lw/sw: AluSrcB = 11, Aluc = 00, go to MEM.
  - beq/bne: AluSrcB = 00, Aluc = 01, PcSrc = 01; PcWrite = Z (beq) or ~Z (bne); go to IF.
  - Arithmetic ops: if OVF_TRAP and V = 1 on add/sub/addi, go to EXC with Cause = 0; otherwise go to WB.
  - V is ignored for and/or/andi/ori.
- MEM:
  - IorD = 1.
  - lw: MemRead = 1, wait for Mrdy, then go to WB.
  - sw: MemWrite = 1 held until Mrdy, then go to IF.
- WB:
  - RegWrite = 1 for exactly one cycle.
  - RegDst = 1 for R-type; MemToReg = 1 for lw.
  - Go to IF.
- EXC:
  - Exc = 1, PcWrite = 1, PcSrc = 11; RegWrite = MemWrite = 0.
  - Go to IF.
- Output timing:
  - Outputs are combinational from the registered state plus Op/Func/Z/V/Mrdy (Mealy only on PcWrite, IrWrite and the next-state choice).
  - Each strobe is a single-cycle pulse except where Mrdy-gated holds apply.
- Latencies with Mrdy = 1:
  - R/I-type ALU op: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - branch: 3 cycles.
  - j: 2 cycles.
  - trap: 4 cycles.
- Rst asserted mid-instruction: return to IF immediately with strobes 0; no partial register write.

Decomposition:
- Package mc_ctrl_pkg holds:
  - State encodings IF = 0, ID = 1, EXE = 2, MEM = 3, WB = 4, EXC = 5.
  - Opcode and Func constants.
  - Aluc constants ALU_ADD = 00, ALU_SUB = 01, ALU_AND = 10, ALU_OR = 11.
- One sub-module, mc_alu_dec: combinational map from Op/Func to Aluc, ExtZ, an illegal flag and an arithmetic-class flag.

Test Plan:
- R-type add, Func = 100000, Mrdy always 1, V = 0 -> states IF, ID, EXE, WB; Aluc = 00 in EXE; RegWrite = 1 and RegDst = 1 in the 4th cycle only.
- beq with Z = 1 -> PcWrite = 1, PcSrc = 01 in EXE. Same with Z = 0 -> PcWrite = 0. bne inverts both results. 3 cycles each.
- lw with Mrdy low for 2 cycles in MEM -> MemRead and IorD = 1 held 3 cycles; WB then has MemToReg = 1, RegDst = 0; total 7 cycles.
- sub with V = 1, OVF_TRAP = 1 -> EXC: Exc = 1, Cause = 0, PcSrc = 11, RegWrite never 1. With OVF_TRAP = 0 -> normal WB.
- Op = 111111 -> ID, then EXC with Cause = 1; andi -> Aluc = 10 and ExtZ = 1 in EXE; j -> PcSrc = 10, back in IF after 2 cycles.
- Rst pulsed in MEM of sw -> State = 0 asynchronously, MemWrite drops the same cycle, fetch resumes after release.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: states,
// opcode/function fields, ALU controls and datapath select codes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EXE = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4,
    ST_EXC = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // ALU operand B sources
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_BROFF = 2'b10;
  localparam logic [1:0] SRCB_IMM   = 2'b11;

  // PC load sources
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_EXC    = 2'b11;

  localparam logic CAUSE_OVF = 1'b0;
  localparam logic CAUSE_ILL = 1'b1;

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational instruction decode: ALU control, immediate extension mode,
// illegal-instruction flag and overflow-capable (arithmetic) flag.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic [1:0] aluc,
  output logic       extz,
  output logic       illegal,
  output logic       arith
);

  always_comb begin
    aluc    = ALU_ADD;
    extz    = 1'b0;
    illegal = 1'b0;
    arith   = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD: begin
            aluc  = ALU_ADD;
            arith = 1'b1;
          end
          FN_SUB: begin
            aluc  = ALU_SUB;
            arith = 1'b1;
          end
          FN_AND:  aluc = ALU_AND;
          FN_OR:   aluc = ALU_OR;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        aluc  = ALU_ADD;
        arith = 1'b1;
      end
      // Logical immediates are zero-extended, so they never overflow
      OP_ANDI: begin
        aluc = ALU_AND;
        extz = 1'b1;
      end
      OP_ORI: begin
        aluc = ALU_OR;
        extz = 1'b1;
      end
      OP_LW, OP_SW, OP_J: aluc = ALU_ADD;
      OP_BEQ, OP_BNE:     aluc = ALU_SUB;
      default:            illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_alu_ctrl.sv
// Multi-cycle control FSM for a MIPS-subset datapath: IF/ID/EXE/MEM/WB/EXC
// sequencing, datapath strobes and overflow / illegal-opcode traps.
module mc_alu_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter bit OVF_TRAP = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  input  logic       Z,
  input  logic       V,
  input  logic       Mrdy,
  output logic [1:0] Aluc,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic       ExtZ,
  output logic       PcWrite,
  output logic [1:0] PcSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IrWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       Exc,
  output logic       Cause,
  output logic [2:0] State
);

  state_e     state_q, state_d;
  logic       cause_q, cause_d;

  logic [1:0] dec_aluc;
  logic       dec_extz;
  logic       dec_illegal;
  logic       dec_arith;

  logic       is_rtype;
  logic       is_lw;
  logic       is_sw;
  logic       is_beq;
  logic       is_br;
  logic       is_j;
  logic       ovf_trap;

  mc_alu_dec u_dec (
    .op      (Op),
    .func    (Func),
    .aluc    (dec_aluc),
    .extz    (dec_extz),
    .illegal (dec_illegal),
    .arith   (dec_arith)
  );

  assign is_rtype = (Op == OP_RTYPE);
  assign is_lw    = (Op == OP_LW);
  assign is_sw    = (Op == OP_SW);
  assign is_beq   = (Op == OP_BEQ);
  assign is_br    = (Op == OP_BEQ) || (Op == OP_BNE);
  assign is_j     = (Op == OP_J);
  assign ovf_trap = OVF_TRAP && dec_arith && V;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_IF: begin
        if (Mrdy) state_d = ST_ID;
      end
      ST_ID: begin
        if (is_j) begin
          state_d = ST_IF;
        end else if (dec_illegal) begin
          state_d = ST_EXC;
          cause_d = CAUSE_ILL;
        end else begin
          state_d = ST_EXE;
        end
      end
      ST_EXE: begin
        if (is_lw || is_sw) begin
          state_d = ST_MEM;
        end else if (is_br) begin
          state_d = ST_IF;
        end else if (ovf_trap) begin
          state_d = ST_EXC;
          cause_d = CAUSE_OVF;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (Mrdy) state_d = is_lw ? ST_WB : ST_IF;
      end
      ST_WB:   state_d = ST_IF;
      ST_EXC:  state_d = ST_IF;
      default: state_d = ST_IF;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IF;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Outputs are gated by Rst directly so strobes drop in the same cycle
  // that reset is raised, without waiting for a clock edge.
  always_comb begin
    Aluc     = ALU_ADD;
    AluSrcA  = 1'b0;
    AluSrcB  = SRCB_REGB;
    ExtZ     = 1'b0;
    PcWrite  = 1'b0;
    PcSrc    = PC_ALU;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IrWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    Exc      = 1'b0;
    Cause    = 1'b0;
    if (!Rst) begin
      case (state_q)
        ST_IF: begin
          MemRead = 1'b1;
          AluSrcB = SRCB_FOUR;
          IrWrite = Mrdy;
          PcWrite = Mrdy;
        end
        ST_ID: begin
          AluSrcB = SRCB_BROFF;
          if (is_j) begin
            PcWrite = 1'b1;
            PcSrc   = PC_JUMP;
          end
        end
        ST_EXE: begin
          AluSrcA = 1'b1;
          Aluc    = dec_aluc;
          ExtZ    = dec_extz;
          AluSrcB = (is_rtype || is_br) ? SRCB_REGB : SRCB_IMM;
          if (is_br) begin
            PcSrc   = PC_ALUOUT;
            PcWrite = is_beq ? Z : ~Z;
          end
        end
        ST_MEM: begin
          IorD     = 1'b1;
          MemRead  = is_lw;
          MemWrite = is_sw;
        end
        ST_WB: begin
          RegWrite = 1'b1;
          RegDst   = is_rtype;
          MemToReg = is_lw;
        end
        ST_EXC: begin
          Exc     = 1'b1;
          PcWrite = 1'b1;
          PcSrc   = PC_EXC;
          Cause   = cause_q;
        end
        default: ;
      endcase
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_mc_alu_ctrl.sv
// Randomized bench for mc_alu_ctrl: two instances (overflow trap on/off) run
// in lockstep against a per-instruction cycle-trace reference model.
module tb_mc_alu_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [5:0] Op, Func;
  logic       Z, V, Mrdy;

  logic [1:0] Aluc_t, AluSrcB_t, PcSrc_t, Aluc_n, AluSrcB_n, PcSrc_n;
  logic       AluSrcA_t, ExtZ_t, PcWrite_t, IorD_t, MemRead_t, MemWrite_t, IrWrite_t;
  logic       RegWrite_t, RegDst_t, MemToReg_t, Exc_t, Cause_t;
  logic       AluSrcA_n, ExtZ_n, PcWrite_n, IorD_n, MemRead_n, MemWrite_n, IrWrite_n;
  logic       RegWrite_n, RegDst_n, MemToReg_n, Exc_n, Cause_n;
  logic [2:0] State_t, State_n;

  mc_alu_ctrl #(.OVF_TRAP(1'b1)) dut_t (
    .Clk(Clk), .Rst(Rst), .Op(Op), .Func(Func), .Z(Z), .V(V), .Mrdy(Mrdy),
    .Aluc(Aluc_t), .AluSrcA(AluSrcA_t), .AluSrcB(AluSrcB_t), .ExtZ(ExtZ_t),
    .PcWrite(PcWrite_t), .PcSrc(PcSrc_t), .IorD(IorD_t), .MemRead(MemRead_t),
    .MemWrite(MemWrite_t), .IrWrite(IrWrite_t), .RegWrite(RegWrite_t),
    .RegDst(RegDst_t), .MemToReg(MemToReg_t), .Exc(Exc_t), .Cause(Cause_t),
    .State(State_t)
  );

  mc_alu_ctrl #(.OVF_TRAP(1'b0)) dut_n (
    .Clk(Clk), .Rst(Rst), .Op(Op), .Func(Func), .Z(Z), .V(V), .Mrdy(Mrdy),
    .Aluc(Aluc_n), .AluSrcA(AluSrcA_n), .AluSrcB(AluSrcB_n), .ExtZ(ExtZ_n),
    .PcWrite(PcWrite_n), .PcSrc(PcSrc_n), .IorD(IorD_n), .MemRead(MemRead_n),
    .MemWrite(MemWrite_n), .IrWrite(IrWrite_n), .RegWrite(RegWrite_n),
    .RegDst(RegDst_n), .MemToReg(MemToReg_n), .Exc(Exc_n), .Cause(Cause_n),
    .State(State_n)
  );

  always #5 Clk = ~Clk;

  // Observed output vector; field positions given by the B_* offsets below
  logic [20:0] obs_t, obs_n;
  assign obs_t = {State_t, Aluc_t, AluSrcA_t, AluSrcB_t, ExtZ_t, PcWrite_t, PcSrc_t,
                  IorD_t, MemRead_t, MemWrite_t, IrWrite_t, RegWrite_t, RegDst_t,
                  MemToReg_t, Exc_t, Cause_t};
  assign obs_n = {State_n, Aluc_n, AluSrcA_n, AluSrcB_n, ExtZ_n, PcWrite_n, PcSrc_n,
                  IorD_n, MemRead_n, MemWrite_n, IrWrite_n, RegWrite_n, RegDst_n,
                  MemToReg_n, Exc_n, Cause_n};

  localparam int B_ST = 18, B_ALUC = 16, B_ASA = 15, B_ASB = 13, B_EXTZ = 12;
  localparam int B_PCW = 11, B_PCSRC = 9, B_IORD = 8, B_MR = 7, B_MW = 6;
  localparam int B_IRW = 5, B_RW = 4, B_RDST = 3, B_M2R = 2, B_EXC = 1, B_CAUSE = 0;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5, K_J = 6, K_ILL = 7;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference trace: one expected (value, mask, Mrdy-to-drive) entry per cycle
  logic [20:0] ce, cm;
  logic [20:0] e_q[$], m_q[$];
  bit          r_q[$];
  int          kcyc;

  task automatic put(input int lsb, input int w, input int val);
    for (int i = 0; i < w; i++) begin
      ce[lsb+i] = val[i];
      cm[lsb+i] = 1'b1;
    end
  endtask

  // Every cycle checks the state and all strobes; they default to 0
  task automatic beg(input int st);
    ce = '0;
    cm = '0;
    put(B_ST, 3, st);
    put(B_PCW, 1, 0); put(B_IRW, 1, 0); put(B_MR, 1, 0);
    put(B_MW, 1, 0);  put(B_RW, 1, 0);  put(B_EXC, 1, 0);
  endtask

  task automatic fin(input bit mrdy);
    e_q.push_back(ce);
    m_q.push_back(cm);
    r_q.push_back(mrdy);
    kcyc++;
  endtask

  task automatic exc_cycle(input int cause, input logic [31:0] noise);
    beg(5);
    put(B_EXC, 1, 1); put(B_PCW, 1, 1); put(B_PCSRC, 2, 3); put(B_CAUSE, 1, cause);
    fin(noise[kcyc % 32]);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input bit z, input bit v,
                       input int wif, input int wmem, input bit ovf, input logic [31:0] noise);
    int  kind, aluc;
    bit  arith, extz, isr;
    kind = K_ILL; aluc = 0; arith = 0; extz = 0;
    e_q.delete(); m_q.delete(); r_q.delete(); kcyc = 0;
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000: begin kind = K_R; aluc = 0; arith = 1; end
          6'b100010: begin kind = K_R; aluc = 1; arith = 1; end
          6'b100100: begin kind = K_R; aluc = 2; end
          6'b100101: begin kind = K_R; aluc = 3; end
          default:   kind = K_ILL;
        endcase
      end
      6'b001000: begin kind = K_I; aluc = 0; arith = 1; end
      6'b001100: begin kind = K_I; aluc = 2; extz = 1; end
      6'b001101: begin kind = K_I; aluc = 3; extz = 1; end
      6'b100011: kind = K_LW;
      6'b101011: kind = K_SW;
      6'b000100: begin kind = K_BEQ; aluc = 1; end
      6'b000101: begin kind = K_BNE; aluc = 1; end
      6'b000010: kind = K_J;
      default:   kind = K_ILL;
    endcase
    isr = (kind == K_R);

    for (int i = 0; i <= wif; i++) begin
      beg(0);
      put(B_MR, 1, 1); put(B_IORD, 1, 0); put(B_ASA, 1, 0); put(B_ASB, 2, 1);
      put(B_ALUC, 2, 0); put(B_PCSRC, 2, 0);
      put(B_IRW, 1, (i == wif) ? 1 : 0); put(B_PCW, 1, (i == wif) ? 1 : 0);
      fin(i == wif);
    end

    beg(1);
    put(B_ASA, 1, 0); put(B_ASB, 2, 2); put(B_ALUC, 2, 0);
    if (kind == K_J) begin
      put(B_PCW, 1, 1); put(B_PCSRC, 2, 2);
      fin(noise[kcyc % 32]);
      return;
    end
    fin(noise[kcyc % 32]);
    if (kind == K_ILL) begin
      exc_cycle(1, noise);
      return;
    end

    beg(2);
    put(B_ALUC, 2, aluc);
    put(B_ASB, 2, (isr || kind == K_BEQ || kind == K_BNE) ? 0 : 3);
    if (isr) put(B_ASA, 1, 1);
    if (kind == K_I) put(B_EXTZ, 1, extz);
    if (kind == K_BEQ || kind == K_BNE) begin
      put(B_PCSRC, 2, 1);
      put(B_PCW, 1, (kind == K_BEQ) ? z : !z);
      fin(noise[kcyc % 32]);
      return;
    end
    fin(noise[kcyc % 32]);

    if (kind == K_LW || kind == K_SW) begin
      for (int i = 0; i <= wmem; i++) begin
        beg(3);
        put(B_IORD, 1, 1);
        put(B_MR, 1, (kind == K_LW) ? 1 : 0);
        put(B_MW, 1, (kind == K_SW) ? 1 : 0);
        fin(i == wmem);
      end
      if (kind == K_SW) return;
    end else if (arith && v && ovf) begin
      exc_cycle(0, noise);
      return;
    end

    beg(4);
    put(B_RW, 1, 1); put(B_RDST, 1, isr); put(B_M2R, 1, (kind == K_LW) ? 1 : 0);
    fin(noise[kcyc % 32]);
  endtask

  logic [20:0] t_exp[$], t_msk[$], n_exp[$], n_msk[$];
  bit          t_mr[$];

  // Entered just after a rising edge with both DUTs in IF
  task automatic run_instr(input int idx, input logic [5:0] op, input logic [5:0] fn,
                           input bit z, input bit v, input int wif, input int wmem);
    logic [31:0] noise;
    noise = $urandom;
    build(op, fn, z, v, wif, wmem, 1'b1, noise);
    t_exp = e_q; t_msk = m_q; t_mr = r_q;
    build(op, fn, z, v, wif, wmem, 1'b0, noise);
    n_exp = e_q; n_msk = m_q;
    Op = op; Func = fn; Z = z; V = v;
    for (int c = 0; c < t_exp.size(); c++) begin
      Mrdy = t_mr[c];
      @(negedge Clk);
      check_val($sformatf("i%0d_trap_c%0d", idx, c), 32'(obs_t & t_msk[c]), 32'(t_exp[c] & t_msk[c]));
      check_val($sformatf("i%0d_notrap_c%0d", idx, c), 32'(obs_n & n_msk[c]), 32'(n_exp[c] & n_msk[c]));
      @(posedge Clk);
      #1;
    end
    $display("instr %0d op=%b func=%b z=%0d v=%0d wif=%0d wmem=%0d cycles=%0d",
             idx, op, fn, z, v, wif, wmem, t_exp.size());
  endtask

  function automatic logic [5:0] pick_op(input int sel);
    case (sel)
      0: return 6'b000000;
      1: return 6'b001000;
      2: return 6'b001100;
      3: return 6'b001101;
      4: return 6'b100011;
      5: return 6'b101011;
      6: return 6'b000100;
      7: return 6'b000101;
      8: return 6'b000010;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] pick_fn(input int sel);
    case (sel)
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    Rst = 1'b1; Op = '0; Func = '0; Z = 1'b0; V = 1'b0; Mrdy = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_val("reset_trap", 32'(obs_t), 32'd0);
    check_val("reset_notrap", 32'(obs_n), 32'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;

    run_instr(0,  6'b000000, 6'b100000, 0, 0, 0, 0); // add
    run_instr(1,  6'b000100, 6'b000000, 1, 0, 0, 0); // beq taken
    run_instr(2,  6'b000100, 6'b000000, 0, 0, 0, 0); // beq not taken
    run_instr(3,  6'b000101, 6'b000000, 1, 0, 0, 0); // bne Z=1
    run_instr(4,  6'b000101, 6'b000000, 0, 0, 0, 0); // bne Z=0
    run_instr(5,  6'b100011, 6'b000000, 0, 0, 0, 2); // lw, 2 wait cycles
    run_instr(6,  6'b000000, 6'b100010, 0, 1, 0, 0); // sub overflow
    run_instr(7,  6'b111111, 6'b000000, 0, 0, 0, 0); // illegal
    run_instr(8,  6'b001100, 6'b000000, 0, 1, 0, 0); // andi, V ignored
    run_instr(9,  6'b000010, 6'b000000, 0, 0, 0, 0); // j
    run_instr(10, 6'b101011, 6'b000000, 0, 0, 1, 1); // sw with waits
    run_instr(11, 6'b000000, 6'b100101, 0, 1, 0, 0); // or, V ignored
    run_instr(12, 6'b001000, 6'b000000, 1, 1, 0, 0); // addi overflow
    run_instr(13, 6'b000000, 6'b111000, 0, 0, 0, 0); // illegal func

    for (int i = 0; i < 200; i++) begin
      logic [5:0] op, fn;
      op = pick_op($urandom_range(0, 11));
      fn = pick_fn($urandom_range(0, 5));
      run_instr(100 + i, op, fn, 1'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // sw interrupted by reset while waiting in MEM
    Op = 6'b101011; Func = '0; Mrdy = 1'b1;
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
    Mrdy = 1'b0;
    @(negedge Clk);
    check_val("sw_in_mem", {28'd0, State_t, MemWrite_t}, {28'd0, 3'd3, 1'b1});
    #2;
    Rst = 1'b1;
    #1;
    check_val("async_rst_trap", 32'(obs_t), 32'd0);
    check_val("async_rst_notrap", 32'(obs_n), 32'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    Mrdy = 1'b1;
    @(negedge Clk);
    check_val("refetch_if", {27'd0, State_t, MemRead_t, IrWrite_t}, {27'd0, 3'd0, 1'b1, 1'b1});
    @(posedge Clk);
    @(negedge Clk);
    check_val("refetch_id", 32'(State_t), 32'd1);
    $display("instr 999 op=%b sw reset in MEM, refetch", Op);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
